alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue controller sitting between decode and the integer ALU of the RV32I core. Accepts one R-type ALU operation at a time over a valid/ready handshake and checks funct7/funct3 legality. Drives the ALU's base/extra enables for exactly one cycle, waits a fixed ALU latency, then captures the result and holds it on a valid/ready output toward writeback.

## Interface
- `ALU_LATENCY`, default 1: cycles from the enable cycle to a valid `alu_result`; legal range 1..15.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode presents an operation.
- `in_ready`  out  1  controller can accept.
- `in_funct7`  in  7  instruction funct7.
- `in_funct3`  in  3  instruction funct3.
- `in_rd`  in  5  destination register.
- `alu_base_enable`  out  1  ALU base-group enable (funct7 = 7'h00).
- `alu_extra_enable`  out  1  ALU extra-group enable (funct7 = 7'h20).
- `alu_funct3`  out  3  funct3 forwarded to the ALU.
- `alu_result`  in  32  ALU result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts.
- `out_rd`  out  5  destination of held result.
- `out_result`  out  32  held result.
- `out_illegal`  out  1  held op was illegal; `out_result` is 0.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `in_ready = 1` (forced 0 while `reset` is high).
  - On `in_valid & in_ready`, latch funct7, funct3 and rd.
  - Legal op: go to ISSUE.
  - Illegal op: go directly to DONE with `out_illegal = 1` and `out_result = 0`. The ALU is never enabled for it.
- Legality:
  - funct7 = 7'h00: any funct3 is legal.
  - funct7 = 7'h20: legal only for funct3 = 3'b000 (SUB) or 3'b101 (SRA).
  - Any other funct7 is illegal.
- ISSUE:
  - Exactly one cycle.
  - `alu_base_enable` = 1 if latched funct7 = 7'h00; `alu_extra_enable` = 1 if it is 7'h20. The two enables are never high together.
  - `alu_funct3` = latched funct3.
  - Load the down-counter with `ALU_LATENCY` and go to WAIT.
- WAIT:
  - Decrement the counter each cycle. Counter width is $clog2(ALU_LATENCY+1).
  - On the cycle the counter equals 1, sample `alu_result` into `out_result` and go to DONE.
- DONE:
  - `out_valid = 1`; `out_rd`, `out_result` and `out_illegal` are stable.
  - On `out_valid & out_ready`, go to IDLE.
  - If `out_ready` is low, hold indefinitely with all outputs unchanged.
- `alu_funct3` holds its last value outside ISSUE; both ALU enables are 0 outside ISSUE.
- Reset, including mid-operation: next state is IDLE; every output register is cleared. Any op in flight is discarded and no `out_valid` is produced for it.
- Reset values: `alu_base_enable` 0, `alu_extra_enable` 0, `alu_funct3` 0, `out_valid` 0, `out_rd` 0, `out_result` 0, `out_illegal` 0, `busy` 0.

## Timing
- Legal op accepted in cycle T:
  - Enable high in cycle T+1 only.
  - `alu_result` sampled at the end of cycle T+1+ALU_LATENCY.
  - `out_valid` high from cycle T+2+ALU_LATENCY.
- Illegal op accepted in cycle T: `out_valid` high from cycle T+1.
- After the output handshake in cycle U, `in_ready` is high in cycle U+1. No same-cycle accept on completion.
- Peak throughput with `out_ready` tied high: one op per ALU_LATENCY+3 cycles.
- `in_valid` while busy: ignored; decode must hold its inputs stable until accepted.
- `alu_result` is ignored in every cycle except the sample cycle.

## Structure
- Shared package `alu_pkg` holds:
  - constants FUNCT7_BASE = 7'h00, FUNCT7_EXTRA = 7'h20, F3_ADD_SUB = 3'b000, F3_SRL_SRA = 3'b101;
  - state enum `alu_issue_state_t` {IDLE, ISSUE, WAIT, DONE}.
- One combinational sub-module, `alu_op_legal`: inputs funct7 and funct3, outputs `legal`, `is_base`, `is_extra`. It is reused by decode.
- Remaining logic is a single FSM with a counter and output registers.

## Test plan
- ADD: funct7 = 0, funct3 = 0, rd = 5, ALU_LATENCY = 1, `alu_result` = 32'h0000_0007, out_ready = 1 → base enable pulses once at T+1, out_valid at T+3 with rd = 5, result 7, illegal 0.
- SRA: funct7 = 7'h20, funct3 = 5, ALU_LATENCY = 3 → only the extra enable pulses, `alu_funct3` = 5, out_valid at T+5.
- Illegal: funct7 = 7'h20, funct3 = 1, or funct7 = 7'h01 → no enable ever, out_valid at T+1 with illegal 1 and result 0.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE while `alu_result` toggles → out_result and out_rd stay stable and in_ready stays 0; release → IDLE next cycle.
- Reset asserted in WAIT → next cycle IDLE, all outputs 0, no out_valid for the dropped op; a fresh op afterwards completes normally.
- Back-to-back: in_valid held high with two queued ops → second accepted exactly one cycle after the first output handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the RV32I R-type ALU issue path.
// Decode uses this package too.
package alu_pkg;

    localparam logic [6:0] FUNCT7_BASE  = 7'h00;
    localparam logic [6:0] FUNCT7_EXTRA = 7'h20;
    localparam logic [2:0] F3_ADD_SUB   = 3'b000;
    localparam logic [2:0] F3_SRL_SRA   = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } alu_issue_state_t;

endpackage

// File: rtl/alu_op_legal.sv
// Combinational funct7/funct3 legality check for R-type ALU operations.
// Decode reuses it, so it must stay free of state.
module alu_op_legal
    import alu_pkg::*;
(
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       legal,
    output logic       is_base,
    output logic       is_extra
);

    always_comb begin
        is_base  = (funct7 == FUNCT7_BASE);
        is_extra = (funct7 == FUNCT7_EXTRA);
        // The extra group only has SUB and SRA.
        legal    = is_base |
                   (is_extra & ((funct3 == F3_ADD_SUB) | (funct3 == F3_SRL_SRA)));
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one R-type op at a time to the integer ALU, waits a fixed latency,
// then holds the captured result toward writeback until it is accepted.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_funct7,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    output logic        alu_base_enable,
    output logic        alu_extra_enable,
    output logic [2:0]  alu_funct3,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_illegal,
    output logic        busy
);

    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    alu_issue_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic             base_en_q, base_en_d;
    logic             extra_en_q, extra_en_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic [31:0]      out_result_q, out_result_d;
    logic             out_illegal_q, out_illegal_d;

    logic op_legal;
    logic op_is_base;
    logic op_is_extra;
    logic accept;

    alu_op_legal u_op_legal (
        .funct7   (in_funct7),
        .funct3   (in_funct3),
        .legal    (op_legal),
        .is_base  (op_is_base),
        .is_extra (op_is_extra)
    );

    assign in_ready = (state_q == IDLE) & ~reset;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        base_en_d     = 1'b0;
        extra_en_d    = 1'b0;
        funct3_d      = funct3_q;
        out_valid_d   = out_valid_q;
        out_rd_d      = out_rd_q;
        out_result_d  = out_result_q;
        out_illegal_d = out_illegal_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d = in_rd;
                    if (op_legal) begin
                        // Enables are registered, so they rise exactly in ISSUE.
                        state_d    = ISSUE;
                        base_en_d  = op_is_base;
                        extra_en_d = op_is_extra;
                        funct3_d   = in_funct3;
                    end else begin
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        out_rd_d      = in_rd;
                        out_result_d  = 32'h0;
                        out_illegal_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(ALU_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_rd_d      = rd_q;
                    out_result_d  = alu_result;
                    out_illegal_d = 1'b0;
                end
            end
            DONE: begin
                // No accept in the handshake cycle; IDLE opens the next cycle.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            base_en_q     <= 1'b0;
            extra_en_q    <= 1'b0;
            funct3_q      <= '0;
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_result_q  <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            base_en_q     <= base_en_d;
            extra_en_q    <= extra_en_d;
            funct3_q      <= funct3_d;
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_result_q  <= out_result_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_base_enable  = base_en_q;
    assign alu_extra_enable = extra_en_q;
    assign alu_funct3       = funct3_q;
    assign out_valid        = out_valid_q;
    assign out_rd           = out_rd_q;
    assign out_result       = out_result_q;
    assign out_illegal      = out_illegal_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (latency 1 and 3), a vector table,
// hand-written reset / back-to-back sequences and a randomized phase.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset            [2];
    logic        in_valid         [2];
    logic        in_ready         [2];
    logic [6:0]  in_funct7        [2];
    logic [2:0]  in_funct3        [2];
    logic [4:0]  in_rd            [2];
    logic        alu_base_enable  [2];
    logic        alu_extra_enable [2];
    logic [2:0]  alu_funct3       [2];
    logic [31:0] alu_result       [2];
    logic        out_valid        [2];
    logic        out_ready        [2];
    logic [4:0]  out_rd           [2];
    logic [31:0] out_result       [2];
    logic        out_illegal      [2];
    logic        busy             [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            alu_issue_ctrl #(.ALU_LATENCY(gi == 0 ? 1 : 3)) dut (
                .clock            (clk),
                .reset            (reset[gi]),
                .in_valid         (in_valid[gi]),
                .in_ready         (in_ready[gi]),
                .in_funct7        (in_funct7[gi]),
                .in_funct3        (in_funct3[gi]),
                .in_rd            (in_rd[gi]),
                .alu_base_enable  (alu_base_enable[gi]),
                .alu_extra_enable (alu_extra_enable[gi]),
                .alu_funct3       (alu_funct3[gi]),
                .alu_result       (alu_result[gi]),
                .out_valid        (out_valid[gi]),
                .out_ready        (out_ready[gi]),
                .out_rd           (out_rd[gi]),
                .out_result       (out_result[gi]),
                .out_illegal      (out_illegal[gi]),
                .busy             (busy[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         d;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [31:0] res;
        int         hold;
        bit         e_base;
        bit         e_extra;
        bit         e_illegal;
        int         e_k;
    } vec_t;

    vec_t vecs[8];

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    // One complete transaction; entered and left at a negedge with the DUT idle.
    task automatic run_op(int d, logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
                          logic [31:0] res, int hold, bit e_base, bit e_extra,
                          bit e_illegal, int e_k, bit chain,
                          logic [6:0] nf7, logic [2:0] nf3, logic [4:0] nrd);
        int base_cnt = 0, extra_cnt = 0, en_k = -1, valid_k = -1;
        logic [2:0] f3_seen = '0;
        logic [31:0] e_res;
        bit stable = 1;
        e_res = e_illegal ? 32'h0 : res;

        chk("in_ready_before_accept", d, in_ready[d], 1);
        in_valid[d]   = 1'b1;
        in_funct7[d]  = f7;
        in_funct3[d]  = f3;
        in_rd[d]      = rd;
        out_ready[d]  = (hold == 0);
        alu_result[d] = $urandom;
        @(posedge clk);
        @(negedge clk);
        if (chain) begin
            in_funct7[d] = nf7;
            in_funct3[d] = nf3;
            in_rd[d]     = nrd;
        end else begin
            in_valid[d]  = 1'b0;
            in_funct7[d] = 7'($urandom);
            in_funct3[d] = 3'($urandom);
            in_rd[d]     = 5'($urandom);
        end
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (alu_base_enable[d]) begin
                base_cnt++; en_k = k; f3_seen = alu_funct3[d];
            end
            if (alu_extra_enable[d]) begin
                extra_cnt++; en_k = k; f3_seen = alu_funct3[d];
            end
            if (out_valid[d]) begin
                valid_k = k;
                break;
            end
            alu_result[d] = (!e_illegal && k == lat(d) + 1) ? res : $urandom;
        end
        chk("out_valid_cycle", d, valid_k, e_k);
        if (valid_k < 0) return;
        chk("base_enable_pulses", d, base_cnt, e_base ? 1 : 0);
        chk("extra_enable_pulses", d, extra_cnt, e_extra ? 1 : 0);
        if (e_base || e_extra) begin
            chk("enable_cycle", d, en_k, 1);
            chk("alu_funct3", d, f3_seen, f3);
        end
        chk("out_rd", d, out_rd[d], rd);
        chk("out_result", d, out_result[d], e_res);
        chk("out_illegal", d, out_illegal[d], e_illegal);
        chk("busy_in_done", d, busy[d], 1);
        chk("in_ready_in_done", d, in_ready[d], 0);
        for (int i = 0; i < hold; i++) begin
            alu_result[d] = $urandom;
            @(negedge clk);
            if (out_valid[d] !== 1'b1 || out_rd[d] !== rd || out_result[d] !== e_res ||
                out_illegal[d] !== e_illegal || in_ready[d] !== 1'b0 ||
                alu_base_enable[d] !== 1'b0 || alu_extra_enable[d] !== 1'b0)
                stable = 0;
        end
        if (hold > 0) chk("backpressure_stable", d, stable, 1);
        out_ready[d] = 1'b1;
        @(negedge clk);
        chk("out_valid_after_handshake", d, out_valid[d], 0);
        chk("in_ready_after_handshake", d, in_ready[d], 1);
        chk("busy_after_handshake", d, busy[d], 0);
    endtask

    task automatic check_cleared(string nm, int d);
        logic [31:0] packed_outs;
        packed_outs = {in_ready[d], alu_base_enable[d], alu_extra_enable[d], alu_funct3[d],
                       out_valid[d], out_rd[d], out_illegal[d], busy[d]};
        chk({nm, "_ctrl_outputs"}, d, packed_outs, 0);
        chk({nm, "_out_result"}, d, out_result[d], 0);
    endtask

    initial begin
        bit saw_valid;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; in_valid[d] = 1'b0; in_funct7[d] = '0; in_funct3[d] = '0;
            in_rd[d] = '0; alu_result[d] = '0; out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_cleared("reset", d);
        for (int d = 0; d < 2; d++) reset[d] = 1'b0;
        @(negedge clk);

        vecs[0] = '{0, 7'h00, 3'd0, 5'd5,  32'h0000_0007, 0,  1, 0, 0, 3};
        vecs[1] = '{1, 7'h20, 3'd5, 5'd9,  32'hDEAD_BEEF, 0,  0, 1, 0, 5};
        vecs[2] = '{1, 7'h20, 3'd1, 5'd3,  32'h0000_1234, 0,  0, 0, 1, 1};
        vecs[3] = '{0, 7'h01, 3'd0, 5'd4,  32'h0000_0055, 0,  0, 0, 1, 1};
        vecs[4] = '{1, 7'h20, 3'd0, 5'd31, 32'h0000_A5A5, 10, 0, 1, 0, 5};
        vecs[5] = '{0, 7'h00, 3'd7, 5'd1,  32'hFFFF_FFFF, 2,  1, 0, 0, 3};
        vecs[6] = '{1, 7'h7F, 3'd5, 5'd2,  32'h0000_0009, 10, 0, 0, 1, 1};
        vecs[7] = '{0, 7'h20, 3'd5, 5'd0,  32'h0000_0042, 0,  0, 1, 0, 3};
        foreach (vecs[i])
            run_op(vecs[i].d, vecs[i].f7, vecs[i].f3, vecs[i].rd, vecs[i].res, vecs[i].hold,
                   vecs[i].e_base, vecs[i].e_extra, vecs[i].e_illegal, vecs[i].e_k,
                   0, '0, '0, '0);

        // Reset while dut1 sits in WAIT: the op is dropped without a result.
        in_valid[1] = 1'b1; in_funct7[1] = 7'h00; in_funct3[1] = 3'd2; in_rd[1] = 5'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_wait", 1, busy[1], 1);
        reset[1] = 1'b1;
        @(negedge clk);
        check_cleared("mid_op_reset", 1);
        reset[1] = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[1]) saw_valid = 1;
        end
        chk("no_valid_for_dropped_op", 1, saw_valid, 0);
        run_op(1, 7'h00, 3'd4, 5'd17, 32'h1357_9BDF, 0, 1, 0, 0, 5, 0, '0, '0, '0);

        // Back-to-back: next op waits on in_valid while busy, accepted at U+1.
        run_op(0, 7'h00, 3'd6, 5'd10, 32'h0000_0011, 0, 1, 0, 0, 3, 1, 7'h20, 3'd0, 5'd12);
        run_op(0, 7'h20, 3'd0, 5'd12, 32'h0000_0022, 0, 0, 1, 0, 3, 0, '0, '0, '0);

        // Randomized ops against a rule-level model.
        for (int n = 0; n < 40; n++) begin
            int d, hold, sel;
            logic [6:0] f7;
            logic [2:0] f3;
            bit is_b, is_e, legal;
            d    = $urandom_range(0, 1);
            hold = $urandom_range(0, 3);
            sel  = $urandom_range(0, 3);
            f7   = (sel == 0) ? 7'h00 : (sel == 3) ? 7'($urandom) : 7'h20;
            f3   = 3'($urandom);
            is_b  = (f7 == 7'h00);
            is_e  = (f7 == 7'h20);
            legal = is_b || (is_e && (f3 == 3'd0 || f3 == 3'd5));
            run_op(d, f7, f3, 5'($urandom), $urandom, hold, legal && is_b, legal && is_e,
                   !legal, legal ? lat(d) + 2 : 1, 0, '0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
